io_uart_tx_fifo: RTL



---
 rtl/io_uart_tx_fifo_pkg.sv | 10 +
 rtl/io_sync_fifo.sv | 45 ++++
 rtl/io_uart_tx_fifo.sv | 124 ++++++++++++
 3 files changed

// File: rtl/io_uart_tx_fifo_pkg.sv
// io_uart_tx_fifo_pkg: IO map bit positions and TX FSM encoding shared by the UART transmitter
package io_uart_tx_fifo_pkg;
  localparam int IO_REGION_BIT = 22;
  localparam int UART_DATA = 1;
  localparam int UART_STATUS = 2;
  localparam int ST_FULL = 9;
  localparam int ST_BUSY = 10;
  localparam int ST_OVF = 11;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/io_sync_fifo.sv
// io_sync_fifo: synchronous FIFO with extra-bit pointers; level port exists only with IO_UART_FIFO_LEVEL_EN
module io_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
`ifdef IO_UART_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic do_push, do_pop;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata = mem[rptr[AW-1:0]];
`ifdef IO_UART_FIFO_LEVEL_EN
  assign level = wptr - rptr;
`endif
  // pointer advance; a pop on a full FIFO frees the slot the same-edge push reuses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end
  // storage needs no reset: emptiness comes from the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/io_uart_tx_fifo.sv
// io_uart_tx_fifo: IO-mapped buffered UART transmitter; IO_UART_FIFO_LEVEL_EN adds occupancy in status[8:0]
module io_uart_tx_fifo
  import io_uart_tx_fifo_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10000000,
  parameter int BAUD_RATE = 1000000,
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_wr,
  output logic [31:0] io_rdata,
  output logic        uart_tx
);
  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shreg, sh_n, fifo_q;
  logic tx_n, pop, push, st_wr, full, empty, ovf, ovf_set, tick, unused_ok;
  logic [31:0] status;
  assign push = io_wr & io_addr[2+UART_DATA];
  assign st_wr = io_wr & io_addr[2+UART_STATUS];
  assign ovf_set = push & full & ~pop;
  assign tick = cnt == '0;
  assign unused_ok = ^{io_addr, io_wdata};
`ifdef IO_UART_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
  io_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk), .resetn(resetn), .push(push), .wdata(io_wdata[7:0]), .pop(pop),
    .rdata(fifo_q), .full(full), .empty(empty), .level(level)
  );
`else
  io_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk), .resetn(resetn), .push(push), .wdata(io_wdata[7:0]), .pop(pop),
    .rdata(fifo_q), .full(full), .empty(empty)
  );
`endif
  // status word built only from registered state so the core can sample it the same cycle
  always_comb begin
    status = '0;
    status[ST_FULL] = full;
    status[ST_BUSY] = ~empty | (state != IDLE);
    status[ST_OVF] = ovf;
`ifdef IO_UART_FIFO_LEVEL_EN
    status[8:0] = 9'(level);
`endif
  end
  assign io_rdata = io_addr[2+UART_STATUS] ? status : '0;
  // sticky overflow; a same-edge set beats a software clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (st_wr & io_wdata[ST_OVF]) ovf <= 1'b0;
  end
  // TX registers; reset abandons any frame and drives the line idle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      uart_tx <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_n;
      shreg <= sh_n;
      uart_tx <= tx_n;
    end
  end
  // frame sequencing; STOP chains straight into START when another byte is waiting
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bit_n = bit_cnt;
    sh_n = shreg;
    tx_n = uart_tx;
    pop = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        sh_n = fifo_q;
        cnt_n = DIV_M1;
        tx_n = 1'b0;
        state_n = START;
      end
      START: if (tick) begin
        state_n = DATA;
        cnt_n = DIV_M1;
        bit_n = '0;
        tx_n = shreg[0];
      end else cnt_n = cnt - 1'b1;
      DATA: if (tick) begin
        cnt_n = DIV_M1;
        if (bit_cnt == 3'd7) begin
          state_n = STOP;
          tx_n = 1'b1;
        end else begin
          bit_n = bit_cnt + 1'b1;
          sh_n = {1'b0, shreg[7:1]};
          tx_n = shreg[1];
        end
      end else cnt_n = cnt - 1'b1;
      STOP: if (tick) begin
        if (!empty) begin
          pop = 1'b1;
          sh_n = fifo_q;
          cnt_n = DIV_M1;
          tx_n = 1'b0;
          state_n = START;
        end else begin
          state_n = IDLE;
          tx_n = 1'b1;
        end
      end else cnt_n = cnt - 1'b1;
      default: state_n = IDLE;
    endcase
  end
endmodule
